// File: rtl/rggen_external_responder_pkg.sv
// Shared encodings for the rggen external-register bus responder:
// access and response-status codes plus a small sizing helper.
package rggen_external_responder_pkg;

    // Access encodings: bit0 = write, bit1 = non-posted.
    localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;
    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_WRITE        = 2'b11;

    // Response status encodings.
    localparam logic [1:0] RGGEN_OKAY         = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
    localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

    // Width of a word index; a single-word bank still needs one bit.
    function automatic int index_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rggen_external_responder_word.sv
// One storage word of the responder: per-byte strobed write with a
// parameterised reset value.
module rggen_external_responder_word #(
    parameter int                   BUS_WIDTH     = 32,
    parameter logic [BUS_WIDTH-1:0] INITIAL_VALUE = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_write_en,
    input  logic [BUS_WIDTH/8-1:0] i_strobe,
    input  logic [BUS_WIDTH-1:0]   i_data,
    output logic [BUS_WIDTH-1:0]   o_value
);

    // Byte-lane write of the stored word, restored to its initial value on reset.
    // NOTE: this storage is a handful of flops, so it takes the async reset value
    // directly; and as sequential state it is written only with non-blocking <=.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value <= INITIAL_VALUE;
        end else if (i_write_en) begin
            for (int k = 0; k < BUS_WIDTH / 8; k++) begin
                if (i_strobe[k]) begin
                    o_value[8*k+:8] <= i_data[8*k+:8];
                end
            end
        end
    end

endmodule

// File: rtl/rggen_external_responder.sv
// rggen external-register bus responder: a bank of WORDS storage registers
// answering read/write requests after WAIT_CYCLES extra wait states.
// Optional feature macro: RGGEN_EXTERNAL_RESPONDER_RANGE_CHECK_EN
// (out-of-range word index answers SLAVE_ERROR instead of silently OKAY).
module rggen_external_responder
    import rggen_external_responder_pkg::*;
#(
    parameter int                             ADDRESS_WIDTH = 8,
    parameter int                             BUS_WIDTH     = 32,
    parameter int                             WORDS         = 4,
    parameter int                             WAIT_CYCLES   = 0,
    parameter logic [WORDS*BUS_WIDTH-1:0]     INITIAL_VALUE = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_external_valid,
    input  logic [1:0]                 i_external_access,
    input  logic [ADDRESS_WIDTH-1:0]   i_external_address,
    input  logic [BUS_WIDTH-1:0]       i_external_data,
    input  logic [BUS_WIDTH/8-1:0]     i_external_strobe,
    output logic                       o_external_ready,
    output logic [1:0]                 o_external_status,
    output logic [BUS_WIDTH-1:0]       o_external_data,
    output logic [WORDS*BUS_WIDTH-1:0] o_value
);

    localparam int BYTE_OFFSET_WIDTH = (BUS_WIDTH > 8) ? $clog2(BUS_WIDTH / 8) : 0;
    localparam int INDEX_WIDTH       = index_width(WORDS);
`ifdef RGGEN_EXTERNAL_RESPONDER_RANGE_CHECK_EN
    // Keep every index bit so indices beyond the bank can be flagged.
    localparam int CAPTURE_WIDTH     = ADDRESS_WIDTH - BYTE_OFFSET_WIDTH;
`else
    // Truncated index; values >= WORDS simply miss every word.
    localparam int CAPTURE_WIDTH     = INDEX_WIDTH;
`endif
    localparam int COUNT_WIDTH       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WAIT,
        STATE_RESP
    } state_e;

    state_e                   state;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     req_write;
    logic [CAPTURE_WIDTH-1:0] req_index;
    logic [BUS_WIDTH-1:0]     req_data;
    logic [BUS_WIDTH/8-1:0]   req_strobe;

    logic [BUS_WIDTH-1:0]     word_value [WORDS];
    logic [BUS_WIDTH-1:0]     read_data;
    logic                     hit;
    logic                     execute;

    // Byte-offset bits and the posted/non-posted flag do not affect behaviour.
    logic unused_inputs;
`ifdef RGGEN_EXTERNAL_RESPONDER_RANGE_CHECK_EN
    assign unused_inputs = ^{i_external_address, i_external_access[1]};
`else
    assign unused_inputs = ^{i_external_address, i_external_access[1], hit};
`endif

    assign execute = (state == STATE_WAIT) && (count == '0);

    // Select the addressed word for reads and flag whether any word matched.
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        read_data = '0;
        hit       = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (req_index == CAPTURE_WIDTH'(i)) begin
                read_data = word_value[i];
                hit       = 1'b1;
            end
        end
    end

    // Storage bank; a word is written on the edge that raises ready.
    for (genvar g = 0; g < WORDS; g++) begin : g_word
        rggen_external_responder_word #(
            .BUS_WIDTH     (BUS_WIDTH),
            .INITIAL_VALUE (INITIAL_VALUE[g*BUS_WIDTH+:BUS_WIDTH])
        ) u_word (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_write_en (execute && req_write && (req_index == CAPTURE_WIDTH'(g))),
            .i_strobe   (req_strobe),
            .i_data     (req_data),
            .o_value    (word_value[g])
        );
        assign o_value[g*BUS_WIDTH+:BUS_WIDTH] = word_value[g];
    end

    // Request FSM: capture, count wait states, then a one-cycle response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= STATE_IDLE;
            count             <= '0;
            req_write         <= 1'b0;
            req_index         <= '0;
            req_data          <= '0;
            req_strobe        <= '0;
            o_external_ready  <= 1'b0;
            o_external_status <= RGGEN_OKAY;
            o_external_data   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (i_external_valid) begin
                        req_write  <= i_external_access[0];
                        req_index  <= i_external_address[BYTE_OFFSET_WIDTH+:CAPTURE_WIDTH];
                        req_data   <= i_external_data;
                        req_strobe <= i_external_strobe;
                        count      <= COUNT_WIDTH'(WAIT_CYCLES);
                        state      <= STATE_WAIT;
                    end
                end
                STATE_WAIT: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        o_external_ready <= 1'b1;
                        o_external_data  <= req_write ? '0 : read_data;
`ifdef RGGEN_EXTERNAL_RESPONDER_RANGE_CHECK_EN
                        o_external_status <= hit ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
`else
                        o_external_status <= RGGEN_OKAY;
`endif
                        state <= STATE_RESP;
                    end
                end
                default: begin
                    o_external_ready  <= 1'b0;
                    o_external_data   <= '0;
                    o_external_status <= RGGEN_OKAY;
                    state             <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_external_responder.sv
// Directed bench for rggen_external_responder: one instance with no wait
// states and four words, one with three wait states and three words.
module tb_rggen_external_responder;
    import rggen_external_responder_pkg::*;

    localparam logic [31:0] W0 = 32'h1122_3344;
    localparam logic [31:0] W1 = 32'hDEAD_BEEF;
    localparam logic [31:0] W2 = 32'h0BAD_F00D;
    localparam logic [31:0] W3 = 32'hCAFE_0123;
    localparam logic [127:0] INIT_A = {W3, W2, W1, W0};
    localparam logic [95:0]  INIT_B = {W2, W1, W0};

`ifdef RGGEN_EXTERNAL_RESPONDER_RANGE_CHECK_EN
    localparam logic [1:0] RANGE_STATUS = RGGEN_SLAVE_ERROR;
`else
    localparam logic [1:0] RANGE_STATUS = RGGEN_OKAY;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_valid, b_valid;
    logic [1:0]   a_access, b_access;
    logic [7:0]   a_address, b_address;
    logic [31:0]  a_wdata, b_wdata;
    logic [3:0]   a_strobe, b_strobe;
    logic         a_ready, b_ready;
    logic [1:0]   a_status, b_status;
    logic [31:0]  a_rdata, b_rdata;
    logic [127:0] a_value;
    logic [95:0]  b_value;

    int n_checks = 0;
    int n_fail   = 0;

    rggen_external_responder #(
        .ADDRESS_WIDTH (8), .BUS_WIDTH (32), .WORDS (4), .WAIT_CYCLES (0),
        .INITIAL_VALUE (INIT_A)
    ) u_dut_a (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_external_valid (a_valid), .i_external_access (a_access),
        .i_external_address (a_address), .i_external_data (a_wdata),
        .i_external_strobe (a_strobe), .o_external_ready (a_ready),
        .o_external_status (a_status), .o_external_data (a_rdata),
        .o_value (a_value)
    );

    rggen_external_responder #(
        .ADDRESS_WIDTH (8), .BUS_WIDTH (32), .WORDS (3), .WAIT_CYCLES (3),
        .INITIAL_VALUE (INIT_B)
    ) u_dut_b (
        .i_clk (clk), .i_rst_n (rst_n),
        .i_external_valid (b_valid), .i_external_access (b_access),
        .i_external_address (b_address), .i_external_data (b_wdata),
        .i_external_strobe (b_strobe), .o_external_ready (b_ready),
        .o_external_status (b_status), .o_external_data (b_rdata),
        .o_value (b_value)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input bit sel, input logic valid, input logic [1:0] access,
                         input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strobe);
        if (sel) begin
            b_valid = valid; b_access = access; b_address = addr; b_wdata = data; b_strobe = strobe;
        end else begin
            a_valid = valid; a_access = access; a_address = addr; a_wdata = data; a_strobe = strobe;
        end
    endtask

    // Issue one request (caller is at a negedge), wait for ready with a bound,
    // drop valid, then confirm ready and data fall back after one cycle.
    task automatic xfer(input string tag, input bit sel, input logic [1:0] access,
                        input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strobe,
                        input bit scramble, output logic [31:0] rdata, output logic [1:0] status,
                        output int edges, output logic [127:0] value_at_ready);
        bit got = 1'b0;
        drive(sel, 1'b1, access, addr, data, strobe);
        edges = 0;
        while (!got && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (sel ? b_ready : a_ready) got = 1'b1;
            else if (scramble)
                drive(sel, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), $urandom, 4'($urandom));
        end
        check({tag, "_ready_seen"}, 128'(got), 128'(1));
        rdata          = sel ? b_rdata : a_rdata;
        status         = sel ? b_status : a_status;
        value_at_ready = sel ? {32'h0, b_value} : a_value;
        drive(sel, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_one_cycle"}, 128'(sel ? b_ready : a_ready), 128'(0));
        check({tag, "_data_cleared"}, 128'(sel ? b_rdata : a_rdata), 128'(0));
    endtask

    initial begin
        logic [31:0]  rdata;
        logic [1:0]   status;
        int           edges;
        logic [127:0] snap;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        #12;
        check("reset_a_value", a_value, INIT_A);
        check("reset_a_ready", 128'(a_ready), 128'(0));
        check("reset_a_status", 128'(a_status), 128'(RGGEN_OKAY));
        check("reset_a_data", 128'(a_rdata), 128'(0));
        check("reset_b_value", 128'(b_value), 128'(INIT_B));
        check("reset_b_ready", 128'(b_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reads with zero wait states; byte offset bits are ignored.
        xfer("a_read1", 1'b0, RGGEN_READ, 8'h04, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("a_read1_data", 128'(rdata), 128'(W1));
        check("a_read1_status", 128'(status), 128'(RGGEN_OKAY));
        check("a_read1_latency", 128'(edges), 128'(2));
        xfer("a_read3", 1'b0, RGGEN_READ, 8'h0F, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("a_read3_data", 128'(rdata), 128'(W3));

        // Strobed write: bytes 0 and 2 take new data, bytes 1 and 3 retained.
        xfer("a_wr0", 1'b0, RGGEN_WRITE, 8'h00, 32'hA5A5_5A5A, 4'b0101, 1'b0, rdata, status, edges, snap);
        check("a_wr0_data", 128'(rdata), 128'(0));
        check("a_wr0_status", 128'(status), 128'(RGGEN_OKAY));
        check("a_wr0_latency", 128'(edges), 128'(2));
        check("a_wr0_value_at_ready", snap, {W3, W2, W1, 32'h11A5_335A});
        xfer("a_rd0", 1'b0, RGGEN_READ, 8'h00, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("a_rd0_data", 128'(rdata), 128'(32'h11A5_335A));

        // All-zero strobe write leaves storage alone.
        xfer("a_wr_nostrb", 1'b0, RGGEN_WRITE, 8'h08, 32'hFFFF_FFFF, 4'b0000, 1'b0, rdata, status, edges, snap);
        check("a_wr_nostrb_status", 128'(status), 128'(RGGEN_OKAY));
        check("a_wr_nostrb_value", a_value, {W3, W2, W1, 32'h11A5_335A});

        // Back-to-back posted write then read, one idle cycle between.
        xfer("a_pw3", 1'b0, RGGEN_POSTED_WRITE, 8'h0C, 32'h1357_9BDF, 4'hF, 1'b0, rdata, status, edges, snap);
        check("a_pw3_status", 128'(status), 128'(RGGEN_OKAY));
        check("a_pw3_value_at_ready", snap, {32'h1357_9BDF, W2, W1, 32'h11A5_335A});
        xfer("a_rd3", 1'b0, RGGEN_READ, 8'h0C, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("a_rd3_data", 128'(rdata), 128'(32'h1357_9BDF));
        check("a_rd3_latency", 128'(edges), 128'(2));

        // Three wait states; inputs scrambled while waiting.
        xfer("b_read1", 1'b1, RGGEN_READ, 8'h04, 32'h0, 4'h0, 1'b1, rdata, status, edges, snap);
        check("b_read1_data", 128'(rdata), 128'(W1));
        check("b_read1_status", 128'(status), 128'(RGGEN_OKAY));
        check("b_read1_latency", 128'(edges), 128'(5));
        check("b_read1_value", 128'(b_value), 128'(INIT_B));

        xfer("b_wr0", 1'b1, RGGEN_WRITE, 8'h00, 32'h7700_0000, 4'b1000, 1'b1, rdata, status, edges, snap);
        check("b_wr0_latency", 128'(edges), 128'(5));
        check("b_wr0_value_at_ready", snap, {32'h0, W2, W1, 32'h7722_3344});

        // Index 3 is beyond a three-word bank.
        xfer("b_oor_rd", 1'b1, RGGEN_READ, 8'h0C, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("b_oor_rd_status", 128'(status), 128'(RANGE_STATUS));
        check("b_oor_rd_data", 128'(rdata), 128'(0));
        check("b_oor_rd_latency", 128'(edges), 128'(5));
        xfer("b_oor_wr", 1'b1, RGGEN_WRITE, 8'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0, rdata, status, edges, snap);
        check("b_oor_wr_status", 128'(status), 128'(RANGE_STATUS));
        check("b_oor_wr_value", 128'(b_value), 128'({W2, W1, 32'h7722_3344}));

        // Reset in the middle of a write to word2: aborted, no ready pulse.
        drive(1'b1, 1'b1, RGGEN_WRITE, 8'h08, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("rst_mid_b_ready", 128'(b_ready), 128'(0));
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid_no_ready_after", 128'(b_ready), 128'(0));
        end
        check("rst_mid_b_value", 128'(b_value), 128'(INIT_B));
        check("rst_mid_a_value", a_value, INIT_A);
        xfer("b_after_rst", 1'b1, RGGEN_READ, 8'h08, 32'h0, 4'h0, 1'b0, rdata, status, edges, snap);
        check("b_after_rst_data", 128'(rdata), 128'(W2));
        check("b_after_rst_latency", 128'(edges), 128'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
